// File: rtl/dcs_pkg.sv
// Shared types for the serial data chain: sample word type and deserializer states.
package dcs_pkg;
   localparam int SAMPLE_W = 8;
   typedef logic signed [SAMPLE_W-1:0] sample_t;
   typedef enum logic [1:0] {DS_IDLE, DS_ALIGN, DS_SHIFT} deser_state_t;
endpackage

// File: rtl/deserializer.sv
// Rebuilds signed MSB-first words from the framed serial bitstream, dropping the
// leading alignment bits and flagging frames that stop mid-word.
module deserializer #(
   parameter int DATA_WIDTH = 8,
   parameter int SKIP_BITS  = 1,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         serial_in,
   input  logic                         start_in,
   output logic signed [DATA_WIDTH-1:0] parallel_out,
   output logic                         data_valid,
   output logic                         busy,
   output logic                         frame_error,
   output logic [CNT_WIDTH-1:0]         word_count
);
   import dcs_pkg::*;

   localparam int BCW = $clog2(DATA_WIDTH) + 1;
   localparam logic [BCW-1:0] LAST_BIT   = BCW'(DATA_WIDTH - 1);
   localparam logic [BCW-1:0] ALIGN_LAST = BCW'((SKIP_BITS > 1) ? SKIP_BITS - 1 : 0);

   deser_state_t          state_q, state_d;
   logic [DATA_WIDTH-1:0] shift_q, shift_d;
   logic [BCW-1:0]        bit_cnt_q, bit_cnt_d;
   logic [BCW-1:0]        align_cnt_q, align_cnt_d;
   logic                  done_q, done_d;
   logic                  frame_error_q, frame_error_d;
   logic [DATA_WIDTH-1:0] parallel_q;
   logic                  data_valid_q;
   logic [CNT_WIDTH-1:0]  word_count_q;

   always_comb begin
      state_d       = state_q;
      shift_d       = shift_q;
      bit_cnt_d     = bit_cnt_q;
      align_cnt_d   = align_cnt_q;
      done_d        = 1'b0;
      frame_error_d = 1'b0;
      case (state_q)
         DS_IDLE: begin
            if (start_in) begin
               bit_cnt_d   = '0;
               align_cnt_d = '0;
               // The rising-edge cycle already holds the first alignment bit (or
               // the first data bit when nothing is skipped), so a single skip bit
               // is fully consumed here and ALIGN is only visited for longer runs.
               if (SKIP_BITS == 0) begin
                  shift_d   = {shift_q[DATA_WIDTH-2:0], serial_in};
                  bit_cnt_d = BCW'(1);
                  state_d   = DS_SHIFT;
               end else if (SKIP_BITS == 1) begin
                  state_d = DS_SHIFT;
               end else begin
                  align_cnt_d = BCW'(1);
                  state_d     = DS_ALIGN;
               end
            end
         end
         DS_ALIGN: begin
            if (!start_in) begin
               state_d       = DS_IDLE;
               align_cnt_d   = '0;
               frame_error_d = 1'b1;
            end else if (align_cnt_q == ALIGN_LAST) begin
               align_cnt_d = '0;
               state_d     = DS_SHIFT;
            end else begin
               align_cnt_d = align_cnt_q + BCW'(1);
            end
         end
         DS_SHIFT: begin
            if (!start_in) begin
               state_d       = DS_IDLE;
               frame_error_d = (bit_cnt_q != '0);
               bit_cnt_d     = '0;
               shift_d       = '0;
            end else begin
               shift_d = {shift_q[DATA_WIDTH-2:0], serial_in};
               if (bit_cnt_q == LAST_BIT) begin
                  bit_cnt_d = '0;
                  done_d    = 1'b1;
               end else begin
                  bit_cnt_d = bit_cnt_q + BCW'(1);
               end
            end
         end
         default: state_d = DS_IDLE;
      endcase
   end

   // The completed word sits in shift_q for one cycle before it is published,
   // giving the one-edge output latency after the last data bit.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= DS_IDLE;
         shift_q       <= '0;
         bit_cnt_q     <= '0;
         align_cnt_q   <= '0;
         done_q        <= 1'b0;
         frame_error_q <= 1'b0;
         parallel_q    <= '0;
         data_valid_q  <= 1'b0;
         word_count_q  <= '0;
      end else begin
         state_q       <= state_d;
         shift_q       <= shift_d;
         bit_cnt_q     <= bit_cnt_d;
         align_cnt_q   <= align_cnt_d;
         done_q        <= done_d;
         frame_error_q <= frame_error_d;
         data_valid_q  <= done_q;
         if (done_q) begin
            parallel_q   <= shift_q;
            word_count_q <= word_count_q + CNT_WIDTH'(1);
         end
      end
   end

   assign parallel_out = parallel_q;
   assign data_valid   = data_valid_q;
   assign busy         = (state_q != DS_IDLE);
   assign frame_error  = frame_error_q;
   assign word_count   = word_count_q;

endmodule
